// File: rtl/somador_serial.sv
// Bit-serial N-bit adder: one full-adder cell reused over N clocks, LSB first.
// The carry travels between bits through a flop, never through a combinational chain.

// Single-bit full-adder stage shared by every bit position
module somador_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module somador_serial #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] S,
   output logic         Cout
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SOMA,
      FIM
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic [N-1:0]  sum_sh;
   logic          carry;
   logic [CW-1:0] cnt;
   logic          fa_s;
   logic          fa_c;
   logic          last_bit;

   assign last_bit = (cnt == CW'(N - 1));

   somador_1bit u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // State register; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and status outputs; start is only honoured in IDLE
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SOMA;
            end
         end
         SOMA: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = FIM;
            end
         end
         FIM: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: capture operands on accept, shift one bit pair per clock, publish on the last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         S      <= '0;
         Cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  carry <= Cin;
                  cnt   <= '0;
               end
            end
            SOMA: begin
               sum_sh <= {fa_s, sum_sh[N-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_c;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  S    <= {fa_s, sum_sh[N-1:1]};
                  Cout <= fa_c;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: timing model plus result scoreboard.
module tb_somador_serial;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         Cin;
   logic         busy;
   logic         done;
   logic [N-1:0] S;
   logic         Cout;

   int           assert_count = 0;
   int           fail_count   = 0;
   int           done_count   = 0;
   int           mdl_cnt      = 0;
   logic [N:0]   held_exp     = '0;
   logic [N:0]   exp_q[$];

   somador_serial #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .Cout  (Cout)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Reference timing model: a countdown of busy cycles, pushing A+B+Cin when a start is accepted
   always @(posedge clk or negedge rst_n) begin
      logic [N:0] e;
      if (!rst_n) begin
         mdl_cnt = 0;
         exp_q.delete();
      end else if (mdl_cnt != 0) begin
         mdl_cnt = mdl_cnt - 1;
      end else if (start) begin
         e = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
         exp_q.push_back(e);
         mdl_cnt = N + 1;
      end
   end

   // Per-cycle monitor on the falling edge: busy/done timing and held result
   always @(negedge clk) begin
      if (!rst_n) begin
         held_exp = '0;
      end else if (mdl_cnt == 1) begin
         if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            held_exp = exp_q.pop_front();
         end
      end
      if (done) done_count++;
      checkOutput("busy", 32'(busy), 32'(mdl_cnt != 0));
      checkOutput("done", 32'(done), 32'(mdl_cnt == 1));
      checkOutput("sum_held", 32'({Cout, S}), 32'(held_exp));
   end

   // Present one start pulse with operands; returns in the first SOMA cycle
   task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      @(negedge clk);
      A     = a;
      B     = b;
      Cin   = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Bounded wait for done; reports the number of falling edges waited
   task automatic waitDone(output int n);
      n = 0;
      while (n < 4 * N) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      int dc0;
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      Cin   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_sum", 32'({Cout, S}), 32'd0);
      rst_n = 1'b1;

      $display("[TB] basic add");
      applyStimulus(8'h5A, 8'h3C, 1'b0);
      waitDone(n);
      checkOutput("latency", 32'(n), 32'(N));
      checkOutput("t1_S", 32'(S), 32'h96);
      checkOutput("t1_Cout", 32'(Cout), 32'd0);

      $display("[TB] carry boundaries");
      applyStimulus(8'hFF, 8'h01, 1'b0);
      waitDone(n);
      checkOutput("t2a_S", 32'(S), 32'h00);
      checkOutput("t2a_Cout", 32'(Cout), 32'd1);
      applyStimulus(8'hFF, 8'hFF, 1'b1);
      waitDone(n);
      checkOutput("t2b_S", 32'(S), 32'hFF);
      checkOutput("t2b_Cout", 32'(Cout), 32'd1);

      $display("[TB] start ignored while busy");
      @(negedge clk);
      applyStimulus(8'h10, 8'h20, 1'b0);
      dc0   = done_count;
      A     = 8'hAA;
      B     = 8'h00;
      start = 1'b1;
      repeat (N + 1) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t3_one_done", 32'(done_count - dc0), 32'd1);
      checkOutput("t3_S", 32'(S), 32'h30);

      $display("[TB] reset mid-operation");
      applyStimulus(8'h77, 8'h11, 1'b0);
      dc0 = done_count;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t4_busy", 32'(busy), 32'd0);
      checkOutput("t4_sum", 32'({Cout, S}), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2 * N) @(negedge clk);
      checkOutput("t4_no_done", 32'(done_count - dc0), 32'd0);
      applyStimulus(8'h01, 8'h02, 1'b0);
      waitDone(n);
      checkOutput("t4_S", 32'(S), 32'h03);

      $display("[TB] back-to-back with start held");
      @(negedge clk);
      dc0 = done_count;
      start = 1'b1;
      repeat (4 * (N + 2)) begin
         A   = N'($urandom);
         B   = N'($urandom);
         Cin = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (2 * N) @(negedge clk);
      checkOutput("t5_dones", 32'(done_count - dc0), 32'd4);

      $display("[TB] random operands");
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(N'($urandom), N'($urandom), 1'($urandom));
         waitDone(n);
      end
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
